// File: rtl/td4_clock_control.sv
// td4_clock_control
//   Generates the single-cycle clock enable for the TD4 core. In AUTO mode,
//   one pulse follows each rising edge of the prescaled slow_clock. In manual
//   mode, one pulse follows each debounced press of step_button.
//
// Build option:
//   TD4_STEP_DEBOUNCE_EN  when defined, the button must disagree with the
//                         accepted level for DEBOUNCE_CYCLES consecutive cycles
//                         before the new level is accepted. When undefined,
//                         the synchronized button is used directly.
//
// Ports:
//   clock_in     100 MHz system clock (only clock)
//   reset_n      asynchronous active-low reset
//   slow_clock   prescaled clock, already registered in clock_in domain
//   mode_manual  slide switch, async (1 = manual step, 0 = auto)
//   step_button  push button, async, active-high, bouncing
//   cpu_enable   registered one-cycle enable pulse for the core
//   pulse_count  number of cpu_enable pulses issued (mod 256)
//   manual_led   high while in a manual state
module td4_clock_control #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       slow_clock,
    input  logic       mode_manual,
    input  logic       step_button,
    output logic       cpu_enable,
    output logic [7:0] pulse_count,
    output logic       manual_led
);

    typedef enum logic [1:0] {
        AUTO        = 2'd0,
        MANUAL_IDLE = 2'd1,
        MANUAL_HELD = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] mode_sync;
    logic [1:0] btn_sync;
    logic       mode_s;
    logic       btn_s;
    logic       btn_db;
    logic       slow_prev;
    logic       tick;
    logic       step_rise;

    // Two-flop synchronizers for the asynchronous switch and button.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            mode_sync <= 2'b00;
            btn_sync  <= 2'b00;
        end else begin
            mode_sync <= {mode_sync[0], mode_manual};
            btn_sync  <= {btn_sync[0], step_button};
        end
    end

    assign mode_s = mode_sync[1];
    assign btn_s  = btn_sync[1];

    // slow_prev resets high so a slow_clock that is already high when reset
    // is released does not produce a tick. The first pulse waits for a real
    // low-to-high transition.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) slow_prev <= 1'b1;
        else          slow_prev <= slow_clock;
    end

    assign tick = slow_clock & ~slow_prev;

`ifdef TD4_STEP_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] db_cnt;

    // Count consecutive samples that disagree with the accepted level.
    // Any agreeing sample restarts the count, so bounce never accumulates.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            btn_db <= 1'b0;
            db_cnt <= '0;
        end else if (btn_s != btn_db) begin
            if (db_cnt == CNT_LAST) begin
                btn_db <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end else begin
            db_cnt <= '0;
        end
    end
`else
    // No filtering: the synchronized level is the accepted level.
    logic unused_debounce;
    assign unused_debounce = ^DEBOUNCE_CYCLES;
    assign btn_db = btn_s;
`endif

    // A mode change always takes priority over a pulse. A manual press is
    // recognised in MANUAL_IDLE (step_rise) and issued one cycle later from
    // MANUAL_HELD, unless the switch leaves manual mode in that cycle.
    // Entering manual mode with the button down lands directly in
    // MANUAL_HELD, so a release and a new press are needed before a pulse.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state       <= AUTO;
            cpu_enable  <= 1'b0;
            pulse_count <= 8'd0;
            step_rise   <= 1'b0;
        end else begin
            cpu_enable <= 1'b0;
            step_rise  <= 1'b0;
            case (state)
                AUTO: begin
                    if (mode_s) begin
                        state <= btn_db ? MANUAL_HELD : MANUAL_IDLE;
                    end else if (tick) begin
                        cpu_enable  <= 1'b1;
                        pulse_count <= pulse_count + 8'd1;
                    end
                end
                MANUAL_IDLE: begin
                    if (!mode_s) begin
                        state <= AUTO;
                    end else if (btn_db) begin
                        state     <= MANUAL_HELD;
                        step_rise <= 1'b1;
                    end
                end
                MANUAL_HELD: begin
                    if (!mode_s) begin
                        state <= AUTO;
                    end else begin
                        if (!btn_db) state <= MANUAL_IDLE;
                        if (step_rise) begin
                            cpu_enable  <= 1'b1;
                            pulse_count <= pulse_count + 8'd1;
                        end
                    end
                end
                default: state <= AUTO;
            endcase
        end
    end

    assign manual_led = (state != AUTO);

endmodule

// File: tb/tb_td4_clock_control.sv
// Directed bench for td4_clock_control with DEBOUNCE_CYCLES = 4. Expected
// latencies and bounce results depend on whether TD4_STEP_DEBOUNCE_EN is set.
module tb_td4_clock_control;

    localparam int DBC = 4;
`ifdef TD4_STEP_DEBOUNCE_EN
    // 2 sync + 4 debounce + 1 FSM + 1 output register
    localparam int PRESS_LAT     = 8;
    localparam int BOUNCE_PULSES = 1;
`else
    // 2 sync + 1 FSM + 1 output register
    localparam int PRESS_LAT     = 4;
    // Each of the 5 bounce rises, plus the final held press
    localparam int BOUNCE_PULSES = 6;
`endif

    logic       clock_in;
    logic       reset_n;
    logic       slow_clock;
    logic       mode_manual;
    logic       step_button;
    logic       cpu_enable;
    logic [7:0] pulse_count;
    logic       manual_led;

    int passed  = 0;
    int total   = 0;
    int exp_cnt = 0;
    int exp_pulses = 0;
    int pulses  = 0;
    int run     = 0;
    int max_run = 0;

    td4_clock_control #(.DEBOUNCE_CYCLES(DBC)) dut (
        .clock_in    (clock_in),
        .reset_n     (reset_n),
        .slow_clock  (slow_clock),
        .mode_manual (mode_manual),
        .step_button (step_button),
        .cpu_enable  (cpu_enable),
        .pulse_count (pulse_count),
        .manual_led  (manual_led)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    // Count pulses and the longest run of consecutive high cycles.
    always @(negedge clock_in) begin
        if (cpu_enable === 1'b1) begin
            pulses = pulses + 1;
            run    = run + 1;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // One slow_clock period: low for a cycle, high for a cycle.
    task automatic slow_period();
        slow_clock = 1'b0;
        cyc(1);
        slow_clock = 1'b1;
        cyc(1);
    endtask

    initial begin
        reset_n     = 1'b0;
        slow_clock  = 1'b0;
        mode_manual = 1'b0;
        step_button = 1'b0;
        cyc(3);
        chk("reset_cpu_enable", 32'(cpu_enable), 0);
        chk("reset_pulse_count", 32'(pulse_count), 0);
        chk("reset_manual_led", 32'(manual_led), 0);
        reset_n = 1'b1;
        cyc(2);

        // Auto mode: three ticks, each pulse one cycle after the tick.
        for (int i = 0; i < 3; i++) begin
            slow_clock = 1'b1;
            chk("auto_pre_edge", 32'(cpu_enable), 0);
            cyc(1);
            exp_cnt++; exp_pulses++;
            chk("auto_pulse_hi", 32'(cpu_enable), 1);
            chk("auto_count", 32'(pulse_count), 32'(exp_cnt));
            cyc(1);
            chk("auto_pulse_lo", 32'(cpu_enable), 0);
            slow_clock = 1'b0;
            cyc(2);
        end
        chk("auto_count3", 32'(pulse_count), 3);

        // Button is ignored in auto mode.
        step_button = 1'b1; cyc(10);
        step_button = 1'b0; cyc(10);
        chk("auto_ignores_button", 32'(pulse_count), 32'(exp_cnt));

        // Enter manual mode: the switch reaches the FSM after two sync flops.
        mode_manual = 1'b1;
        cyc(2);
        chk("led_before_sync", 32'(manual_led), 0);
        cyc(1);
        chk("led_manual", 32'(manual_led), 1);
        slow_period(); slow_period();
        slow_clock = 1'b0; cyc(2);
        chk("manual_ignores_tick", 32'(pulse_count), 32'(exp_cnt));

        // Clean press: exact latency.
        step_button = 1'b1;
        cyc(PRESS_LAT - 1);
        chk("press_pre", 32'(cpu_enable), 0);
        cyc(1);
        exp_cnt++; exp_pulses++;
        chk("press_pulse", 32'(cpu_enable), 1);
        chk("press_count", 32'(pulse_count), 32'(exp_cnt));
        cyc(1);
        chk("press_pulse_end", 32'(cpu_enable), 0);
        cyc(10);
        chk("held_no_repeat", 32'(pulse_count), 32'(exp_cnt));
        step_button = 1'b0; cyc(15);

        // Bounce: toggle every 2 cycles for 20 cycles, hold 10, release 10.
        for (int i = 0; i < 5; i++) begin
            step_button = 1'b1; cyc(2);
            step_button = 1'b0; cyc(2);
        end
        step_button = 1'b1; cyc(10);
        step_button = 1'b0; cyc(10);
        exp_cnt += BOUNCE_PULSES; exp_pulses += BOUNCE_PULSES;
        chk("bounce_count", 32'(pulse_count), 32'(exp_cnt));
        chk("bounce_pulses", 32'(pulses), 32'(exp_pulses));

        // Back to auto, then enter manual with the button already held.
        mode_manual = 1'b0; cyc(4);
        chk("led_auto", 32'(manual_led), 0);
        step_button = 1'b1; cyc(10);
        mode_manual = 1'b1; cyc(10);
        chk("held_entry_led", 32'(manual_led), 1);
        chk("held_entry_no_pulse", 32'(pulse_count), 32'(exp_cnt));
        step_button = 1'b0; cyc(10);
        chk("held_release_no_pulse", 32'(pulse_count), 32'(exp_cnt));
        step_button = 1'b1; cyc(10);
        exp_cnt++; exp_pulses++;
        chk("repress_pulse", 32'(pulse_count), 32'(exp_cnt));
        step_button = 1'b0; cyc(10);

        // Mode 0->1 reaches the FSM in the same cycle as a tick.
        mode_manual = 1'b0; cyc(5);
        mode_manual = 1'b1;
        cyc(2);
        slow_clock = 1'b1;
        cyc(1);
        chk("simul_no_pulse", 32'(cpu_enable), 0);
        chk("simul_led", 32'(manual_led), 1);
        cyc(1);
        chk("simul_no_late_pulse", 32'(cpu_enable), 0);
        chk("simul_count", 32'(pulse_count), 32'(exp_cnt));
        mode_manual = 1'b0; cyc(4);
        slow_clock = 1'b0; cyc(2);

        // Reset asserted mid-pulse drops cpu_enable immediately.
        slow_clock = 1'b1;
        cyc(1);
        chk("abort_pulse_hi", 32'(cpu_enable), 1);
        reset_n = 1'b0;
        #1;
        chk("abort_cpu_enable", 32'(cpu_enable), 0);
        chk("abort_count", 32'(pulse_count), 0);
        chk("abort_led", 32'(manual_led), 0);
        exp_cnt = 0;

        // Release reset with slow_clock high: no pulse until a fresh rise.
        cyc(2);
        reset_n = 1'b1;
        cyc(5);
        chk("no_tick_after_reset", 32'(pulse_count), 0);
        chk("no_pulse_after_reset", 32'(pulses), 32'(exp_pulses));
        slow_period();
        exp_cnt++; exp_pulses++;
        chk("first_pulse_after_reset", 32'(cpu_enable), 1);
        chk("count_after_reset", 32'(pulse_count), 1);
        for (int i = 0; i < 254; i++) slow_period();
        exp_cnt += 254; exp_pulses += 254;
        chk("count_255", 32'(pulse_count), 255);
        slow_period();
        exp_pulses++;
        chk("wrap_pulse", 32'(cpu_enable), 1);
        chk("wrap_count", 32'(pulse_count), 0);
        slow_clock = 1'b0; cyc(3);

        chk("total_pulses", 32'(pulses), 32'(exp_pulses));
        chk("max_pulse_width", 32'(max_run), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
